// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states,
// stream/word geometry constants and the length bound helper.
package loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_STEP  = 4;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } load_state_t;

    // Number of words that fit between the base address and the top of memory.
    function automatic int unsigned max_words(input int unsigned mem_size,
                                              input int unsigned base_addr);
        return (mem_size - base_addr) / ADDR_STEP;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Byte-to-word assembler: places each accepted byte into its little-endian
// lane of a 32-bit word and folds it into a running XOR checksum.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear         synchronous restart of lane, word and checksum
//   byte_en       byte_in is accepted this cycle
//   byte_in       stream byte
//   word          assembled word (registered)
//   checksum      XOR of all bytes accepted since the last clear (registered)
//   word_ready_c  the byte accepted this cycle completes a word
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] checksum,
    output logic              word_ready_c
);

    logic [LANE_W-1:0] lane;

    assign word_ready_c = byte_en && (lane == LANE_W'(WORD_BYTES - 1));

    // Lane placement overwrites every lane of each word, so no stale bytes survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane     <= '0;
            word     <= '0;
            checksum <= '0;
        end else if (clear) begin
            lane     <= '0;
            word     <= '0;
            checksum <= '0;
        end else if (byte_en) begin
            word[{lane, 3'b000} +: BYTE_W] <= byte_in;
            lane                           <= lane + LANE_W'(1);
            checksum                       <= checksum ^ byte_in;
        end
    end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory loader: parses a length-prefixed, XOR-checksummed byte
// stream, writes little-endian words to consecutive addresses from BASE_ADDR,
// and holds the CPU until a load completes with a matching checksum.
// Ports:
//   CLK, RESET           clock, async active-low reset
//   START                one-cycle pulse to begin a load (IDLE/DONE/ERROR only)
//   BYTE_IN/BYTE_VALID   stream byte and its valid
//   BYTE_READY           loader accepts a byte (registered, independent of valid)
//   WRITE_ENABLE/ADDRESS/DATA  instruction memory write port
//   WORDS_WRITTEN        words written in the current load
//   CPU_HOLD, LOAD_DONE, LOAD_ERROR  status
module instruction_memory_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [BYTE_W-1:0] BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              WRITE_ENABLE,
    output logic [ADDR_W-1:0] WRITE_ADDRESS,
    output logic [WORD_W-1:0] WRITE_DATA,
    output logic [LEN_W-1:0]  WORDS_WRITTEN,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERROR
);

    localparam int unsigned MAX_WORDS = max_words(MEM_SIZE, BASE_ADDR);

    load_state_t       state, state_n;
    logic [LEN_W-1:0]  target, target_n;
    logic [LEN_W-1:0]  count_n;
    logic [LEN_W-1:0]  len_c;
    logic [ADDR_W-1:0] addr_n;
    logic              ready_n, we_n, hold_n, done_n, error_n;
    logic              accept_c, clear_c, data_en_c, word_ready_c;
    logic [BYTE_W-1:0] checksum;

    assign accept_c = BYTE_VALID && BYTE_READY;
    // Full length once the high byte arrives; the low byte was parked in target.
    assign len_c    = {BYTE_IN, target[BYTE_W-1:0]};

    byte_word_assembler u_assembler (
        .clk          (CLK),
        .rst_n        (RESET),
        .clear        (clear_c),
        .byte_en      (data_en_c),
        .byte_in      (BYTE_IN),
        .word         (WRITE_DATA),
        .checksum     (checksum),
        .word_ready_c (word_ready_c)
    );

    // Next state, counters and the next value of every registered output.
    always_comb begin
        state_n   = state;
        target_n  = target;
        count_n   = WORDS_WRITTEN;
        addr_n    = WRITE_ADDRESS;
        clear_c   = 1'b0;
        data_en_c = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (START) begin
                    clear_c  = 1'b1;
                    target_n = '0;
                    count_n  = '0;
                    addr_n   = ADDR_W'(BASE_ADDR);
                    state_n  = LEN0;
                end
            end
            LEN0: begin
                if (accept_c) begin
                    target_n = LEN_W'(BYTE_IN);
                    state_n  = LEN1;
                end
            end
            LEN1: begin
                if (accept_c) begin
                    target_n = len_c;
                    if (len_c == '0) begin
                        state_n = DONE;
                    end else if (32'(len_c) > MAX_WORDS) begin
                        state_n = ERROR;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                data_en_c = accept_c;
                if (word_ready_c) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                addr_n  = WRITE_ADDRESS + ADDR_W'(ADDR_STEP);
                count_n = WORDS_WRITTEN + LEN_W'(1);
                state_n = (count_n == target) ? CHK : DATA;
            end
            CHK: begin
                if (accept_c) begin
                    state_n = (BYTE_IN == checksum) ? DONE : ERROR;
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == LEN0) || (state_n == LEN1) ||
                  (state_n == DATA) || (state_n == CHK);
        we_n    = (state_n == WRITE);
        done_n  = (state_n == DONE);
        error_n = (state_n == ERROR);
        hold_n  = (state_n != DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            target        <= '0;
            WORDS_WRITTEN <= '0;
            WRITE_ADDRESS <= ADDR_W'(BASE_ADDR);
            BYTE_READY    <= 1'b0;
            WRITE_ENABLE  <= 1'b0;
            CPU_HOLD      <= 1'b1;
            LOAD_DONE     <= 1'b0;
            LOAD_ERROR    <= 1'b0;
        end else begin
            state         <= state_n;
            target        <= target_n;
            WORDS_WRITTEN <= count_n;
            WRITE_ADDRESS <= addr_n;
            BYTE_READY    <= ready_n;
            WRITE_ENABLE  <= we_n;
            CPU_HOLD      <= hold_n;
            LOAD_DONE     <= done_n;
            LOAD_ERROR    <= error_n;
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench for instruction_memory_loader: table of whole-stream
// loads with expected writes/status, plus hand sequences for reset mid-word,
// restart from DONE, START ignored during DATA and the maximum legal length.
`timescale 1ns/1ps
module tb_instruction_memory_loader;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic        WRITE_ENABLE;
    logic [31:0] WRITE_ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [15:0] WORDS_WRITTEN;
    logic        CPU_HOLD;
    logic        LOAD_DONE;
    logic        LOAD_ERROR;

    instruction_memory_loader #(.MEM_SIZE(1024), .BASE_ADDR(0)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START         (START),
        .BYTE_IN       (BYTE_IN),
        .BYTE_VALID    (BYTE_VALID),
        .BYTE_READY    (BYTE_READY),
        .WRITE_ENABLE  (WRITE_ENABLE),
        .WRITE_ADDRESS (WRITE_ADDRESS),
        .WRITE_DATA    (WRITE_DATA),
        .WORDS_WRITTEN (WORDS_WRITTEN),
        .CPU_HOLD      (CPU_HOLD),
        .LOAD_DONE     (LOAD_DONE),
        .LOAD_ERROR    (LOAD_ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];

    typedef struct packed {
        logic [127:0] stream;   // bytes left-justified, first byte in [127:120]
        int           nb;
        int           gap;
        int           nw;
        logic [31:0]  a0, d0, a1, d1;
        logic         done;
        logic         err;
        logic [15:0]  words;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Record every write; the loader must not take a byte while writing.
    always @(negedge CLK) begin
        if (RESET && WRITE_ENABLE) begin
            wq_a.push_back(WRITE_ADDRESS);
            wq_d.push_back(WRITE_DATA);
            check("ready_low_in_write", 32'(BYTE_READY), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        BYTE_VALID = 1'b1;
        BYTE_IN    = b;
        while (BYTE_READY !== 1'b1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (BYTE_READY !== 1'b1) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            BYTE_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            BYTE_VALID = 1'b0;
        end
    endtask

    task automatic add_vec(input logic [127:0] raw, input int nb, input int gap, input int nw,
                           input logic [31:0] a0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] d1,
                           input logic done, input logic err, input logic [15:0] words);
        vec_t v;
        v.stream = raw << (128 - 8 * nb);
        v.nb = nb; v.gap = gap; v.nw = nw;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.done = done; v.err = err; v.words = words;
        vecs.push_back(v);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic [15:0] words);
        check({tag, "_done"},  32'(LOAD_DONE),     32'(done));
        check({tag, "_error"}, 32'(LOAD_ERROR),    32'(err));
        check({tag, "_hold"},  32'(CPU_HOLD),      32'(!done));
        check({tag, "_words"}, 32'(WORDS_WRITTEN), 32'(words));
        check({tag, "_ready"}, 32'(BYTE_READY),    32'd0);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit do_start);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea[0] = v.a0; ea[1] = v.a1; ed[0] = v.d0; ed[1] = v.d1;
        wq_a.delete();
        wq_d.delete();
        if (do_start) pulse_start();
        for (int i = 0; i < v.nb; i++) send_byte(v.stream[127 - 8 * i -: 8], v.gap);
        repeat (3) @(negedge CLK);
        check_status(tag, v.done, v.err, v.words);
        check({tag, "_nwrites"}, 32'(wq_a.size()), 32'(v.nw));
        for (int i = 0; i < v.nw && i < wq_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_a[i], ea[i]);
            check($sformatf("%s_data%0d", tag, i), wq_d[i], ed[i]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(BYTE_READY),    32'd0);
        check({tag, "_we"},    32'(WRITE_ENABLE),  32'd0);
        check({tag, "_addr"},  WRITE_ADDRESS,      32'd0);
        check({tag, "_data"},  WRITE_DATA,         32'd0);
        check({tag, "_words"}, 32'(WORDS_WRITTEN), 32'd0);
        check({tag, "_hold"},  32'(CPU_HOLD),      32'd1);
        check({tag, "_done"},  32'(LOAD_DONE),     32'd0);
        check({tag, "_error"}, 32'(LOAD_ERROR),    32'd0);
    endtask

    function automatic logic [7:0] big_byte(input int j);
        return 8'(j * 3 + 1);
    endfunction

    initial begin
        vec_t tail;
        logic [7:0]  chk;
        logic [31:0] exp_w;
        int          bad;

        RESET = 1'b0; START = 1'b0; BYTE_VALID = 1'b0; BYTE_IN = 8'h00;

        // Normal, bad checksum, zero length, over-length, throttled, single word.
        add_vec(128'({8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h13,8'h01,8'h10,8'h00,8'h11}), 11, 0, 2,
                32'h0, 32'h00000013, 32'h4, 32'h00100113, 1'b1, 1'b0, 16'd2);
        add_vec(128'({8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h13,8'h01,8'h10,8'h00,8'h12}), 11, 0, 2,
                32'h0, 32'h00000013, 32'h4, 32'h00100113, 1'b0, 1'b1, 16'd2);
        add_vec(128'({8'h00,8'h00}), 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 16'd0);
        add_vec(128'({8'h01,8'h01}), 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0);
        add_vec(128'({8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h13,8'h01,8'h10,8'h00,8'h11}), 11, 3, 2,
                32'h0, 32'h00000013, 32'h4, 32'h00100113, 1'b1, 1'b0, 16'd2);
        add_vec(128'({8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22}), 7, 0, 1,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0, 16'd1);

        repeat (2) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b1;
        @(negedge CLK);
        check("idle_ready", 32'(BYTE_READY), 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b1);

        // Reset in the middle of the first word, then a clean reload.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge CLK);
        RESET = 1'b1;
        run_vec("reload", vecs[0], 1'b1);

        // Restart from DONE re-asserts hold and clears status/counters.
        pulse_start();
        check("restart_hold",  32'(CPU_HOLD),      32'd1);
        check("restart_done",  32'(LOAD_DONE),     32'd0);
        check("restart_words", 32'(WORDS_WRITTEN), 32'd0);
        check("restart_addr",  WRITE_ADDRESS,      32'd0);
        check("restart_ready", 32'(BYTE_READY),    32'd1);
        run_vec("restart", vecs[0], 1'b0);

        // START during DATA is ignored; the load continues undisturbed.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        wq_a.delete();
        wq_d.delete();
        pulse_start();
        check("ign_start_ready", 32'(BYTE_READY),    32'd1);
        check("ign_start_words", 32'(WORDS_WRITTEN), 32'd0);
        check("ign_start_hold",  32'(CPU_HOLD),      32'd1);
        tail = vecs[0];
        tail.stream = tail.stream << 32;
        tail.nb     = 7;
        begin
            for (int i = 0; i < tail.nb; i++) send_byte(tail.stream[127 - 8 * i -: 8], 0);
            repeat (3) @(negedge CLK);
            check_status("ign_start", 1'b1, 1'b0, 16'd2);
            check("ign_start_nwrites", 32'(wq_a.size()), 32'd2);
            if (wq_a.size() == 2) begin
                check("ign_start_data0", wq_d[0], 32'h00000013);
                check("ign_start_data1", wq_d[1], 32'h00100113);
                check("ign_start_addr1", wq_a[1], 32'h4);
            end
        end

        // Largest legal length: 256 words fill memory up to byte address 0x3FC.
        wq_a.delete();
        wq_d.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk = 8'h00;
        for (int j = 0; j < 1024; j++) begin
            send_byte(big_byte(j), 0);
            chk = chk ^ big_byte(j);
        end
        send_byte(chk, 0);
        repeat (3) @(negedge CLK);
        check_status("n256", 1'b1, 1'b0, 16'd256);
        check("n256_nwrites", 32'(wq_a.size()), 32'd256);
        bad = 0;
        for (int w = 0; w < wq_a.size() && w < 256; w++) begin
            exp_w = {big_byte(4*w+3), big_byte(4*w+2), big_byte(4*w+1), big_byte(4*w)};
            if (wq_a[w] !== 32'(4 * w) || wq_d[w] !== exp_w) bad++;
        end
        check("n256_write_errors", 32'(bad), 32'd0);
        if (wq_a.size() == 256) check("n256_last_addr", wq_a[255], 32'h3FC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
